// File: rtl/cr_osf_ob_egress_fifo_if.sv
// Bundle between the OSF control stage, the egress FIFO and the CSR readback.
// The FIFO itself takes the slave view; the upstream/egress/CSR environment takes the master view.
interface cr_osf_ob_egress_fifo_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
);
    logic                       ob_wr;
    logic [DATA_W-1:0]          ob_wdata;
    logic                       ob_wlast;
    logic                       ob_afull;
    logic                       m_tvalid;
    logic                       m_tready;
    logic [DATA_W-1:0]          m_tdata;
    logic                       m_tlast;
    logic [$clog2(DEPTH+1)-1:0] ob_depth;
    logic [15:0]                ob_eof_cnt;
    logic                       ob_ovfl;
    logic                       ob_ovfl_clr;

    modport master (
        output ob_wr, ob_wdata, ob_wlast, m_tready, ob_ovfl_clr,
        input  ob_afull, m_tvalid, m_tdata, m_tlast, ob_depth, ob_eof_cnt, ob_ovfl
    );

    modport slave (
        input  ob_wr, ob_wdata, ob_wlast, m_tready, ob_ovfl_clr,
        output ob_afull, m_tvalid, m_tdata, m_tlast, ob_depth, ob_eof_cnt, ob_ovfl
    );
endinterface

// File: rtl/cr_osf_ob_egress_fifo.sv
// Output-buffer FIFO feeding the OSF egress AXI4-stream port from the debug-FIFO control stage.
// Flop storage with pointer/count control, delivered-frame counter and sticky overflow flag.
module cr_osf_ob_egress_fifo #(
    parameter int DATA_W       = 64,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cr_osf_ob_egress_fifo_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - AFULL_MARGIN);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [DATA_W:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      eof_cnt_q, eof_cnt_d;
    logic             ovfl_q, ovfl_d;
    logic             pop, accept, drop;
    logic [DATA_W:0]  rd_entry;

    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    always_comb begin
        pop    = (count_q != '0) && bus.m_tready;
        accept = bus.ob_wr && ((count_q != FULL_CNT) || pop);
        drop   = bus.ob_wr && !accept;

        wptr_d = accept ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop    ? ptr_inc(rptr_q) : rptr_q;

        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        eof_cnt_d = (pop && rd_entry[DATA_W]) ? eof_cnt_q + 16'd1 : eof_cnt_q;
        ovfl_d    = drop ? 1'b1 : (bus.ob_ovfl_clr ? 1'b0 : ovfl_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            eof_cnt_q <= '0;
            ovfl_q    <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            eof_cnt_q <= eof_cnt_d;
            ovfl_q    <= ovfl_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem_q[wptr_q] <= {bus.ob_wlast, bus.ob_wdata};
        end
    end

    assign rd_entry       = mem_q[rptr_q];
    assign bus.m_tvalid   = (count_q != '0);
    assign bus.m_tdata    = rd_entry[DATA_W-1:0];
    assign bus.m_tlast    = rd_entry[DATA_W];
    assign bus.ob_depth   = count_q;
    assign bus.ob_afull   = (count_q >= AFULL_CNT);
    assign bus.ob_eof_cnt = eof_cnt_q;
    assign bus.ob_ovfl    = ovfl_q;
endmodule

// File: tb/tb_cr_osf_ob_egress_fifo.sv
// Scenario bench for the OSF egress output-buffer FIFO (DATA_W=64, DEPTH=8, AFULL_MARGIN=3).
// Written beats go into an expected queue and are matched against each AXI pop.
module tb_cr_osf_ob_egress_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cr_osf_ob_egress_fifo_if #(.DATA_W(64), .DEPTH(8)) bus ();

    cr_osf_ob_egress_fifo #(.DATA_W(64), .DEPTH(8), .AFULL_MARGIN(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [64:0] exp_q[$];
    int          mcount  = 0;
    int          exp_eof = 0;

    // One clock: drive at the falling edge, sample outputs there, return 1 unit after the rising edge.
    task automatic drive_cycle(input logic wr, input logic [63:0] d, input logic last,
                               input logic rdy, input logic clr,
                               output logic vld, output logic popped, output logic [64:0] obs);
        @(negedge clk);
        bus.ob_wr       = wr;
        bus.ob_wdata    = d;
        bus.ob_wlast    = last;
        bus.m_tready    = rdy;
        bus.ob_ovfl_clr = clr;
        vld    = bus.m_tvalid;
        popped = vld && rdy;
        obs    = {bus.m_tlast, bus.m_tdata};
        if (wr && (mcount < 8 || popped)) begin
            exp_q.push_back({last, d});
            mcount++;
        end
        if (popped) mcount--;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int ncyc);
        @(negedge clk);
        rst_n           = 1'b0;
        bus.ob_wr       = 1'b0;
        bus.m_tready    = 1'b0;
        bus.ob_ovfl_clr = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1;
        exp_q.delete();
        mcount  = 0;
        exp_eof = 0;
    endtask

    task automatic test_reset();
        apply_reset(2);
        n_tests++; if (bus.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%0b exp=0", bus.m_tvalid); end
        n_tests++; if (bus.ob_afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull got=%0b exp=0", bus.ob_afull); end
        n_tests++; if (bus.ob_depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth got=%0d exp=0", bus.ob_depth); end
        n_tests++; if (bus.ob_eof_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_eof got=%0d exp=0", bus.ob_eof_cnt); end
        n_tests++; if (bus.ob_ovfl !== 1'b0) begin n_fail++; $display("FAIL reset_ovfl got=%0b exp=0", bus.ob_ovfl); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic vld, popped;
        logic [64:0] obs, e;
        repeat (7) drive_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, vld, popped, obs);
        drive_cycle(1'b1, 64'hA5, 1'b1, 1'b1, 1'b0, vld, popped, obs);
        n_tests++; if (vld !== 1'b0) begin n_fail++; $display("FAIL lat_early got=%0b exp=0", vld); end
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, vld, popped, obs);
        n_tests++;
        if (popped !== 1'b1) begin
            n_fail++; $display("FAIL lat_valid got=%0b exp=1", popped);
        end else begin
            e = exp_q.pop_front(); exp_eof += int'(e[64]);
            n_tests++; if (obs !== e) begin n_fail++; $display("FAIL lat_data got=%h exp=%h", obs, e); end
        end
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, vld, popped, obs);
        n_tests++; if (vld !== 1'b0) begin n_fail++; $display("FAIL lat_single got=%0b exp=0", vld); end
        n_tests++; if (bus.ob_eof_cnt !== 16'(exp_eof)) begin n_fail++; $display("FAIL lat_eof got=%0d exp=%0d", bus.ob_eof_cnt, exp_eof); end
        n_tests++; if (bus.ob_depth !== 4'd0) begin n_fail++; $display("FAIL lat_depth got=%0d exp=0", bus.ob_depth); end
    endtask

    task automatic test_fill_afull();
        logic vld, popped;
        logic [64:0] obs, e;
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b1, 64'(i), (i == 4) || (i == 8), 1'b0, 1'b0, vld, popped, obs);
            n_tests++; if (bus.ob_depth !== 4'(i)) begin n_fail++; $display("FAIL fill_depth beat=%0d got=%0d exp=%0d", i, bus.ob_depth, i); end
            n_tests++; if (bus.ob_afull !== (i >= 5)) begin n_fail++; $display("FAIL fill_afull beat=%0d got=%0b exp=%0b", i, bus.ob_afull, (i >= 5)); end
        end
        drive_cycle(1'b1, 64'd9, 1'b1, 1'b0, 1'b0, vld, popped, obs);
        n_tests++; if (bus.ob_ovfl !== 1'b1) begin n_fail++; $display("FAIL fill_ovfl got=%0b exp=1", bus.ob_ovfl); end
        n_tests++; if (bus.ob_depth !== 4'd8) begin n_fail++; $display("FAIL fill_full_depth got=%0d exp=8", bus.ob_depth); end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, vld, popped, obs);
            n_tests++;
            if (!popped || exp_q.size() == 0) begin
                n_fail++; $display("FAIL fill_drain_valid idx=%0d got=%0b exp=1", i, popped);
            end else begin
                e = exp_q.pop_front(); exp_eof += int'(e[64]);
                if (obs !== e) begin n_fail++; $display("FAIL fill_drain_data idx=%0d got=%h exp=%h", i, obs, e); end
            end
        end
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, vld, popped, obs);
        n_tests++; if (vld !== 1'b0) begin n_fail++; $display("FAIL fill_dropped_absent got=%0b exp=0", vld); end
        n_tests++; if (bus.ob_eof_cnt !== 16'(exp_eof)) begin n_fail++; $display("FAIL fill_eof got=%0d exp=%0d", bus.ob_eof_cnt, exp_eof); end
        n_tests++; if (bus.ob_ovfl !== 1'b0) begin n_fail++; $display("FAIL fill_ovfl_clr got=%0b exp=0", bus.ob_ovfl); end
    endtask

    task automatic test_full_pop();
        logic vld, popped;
        logic [64:0] obs, e;
        for (int i = 1; i <= 8; i++) drive_cycle(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0, 1'b0, vld, popped, obs);
        drive_cycle(1'b1, 64'h1FF, 1'b1, 1'b1, 1'b0, vld, popped, obs);
        n_tests++;
        if (!popped) begin
            n_fail++; $display("FAIL fullpop_valid got=%0b exp=1", popped);
        end else begin
            e = exp_q.pop_front(); exp_eof += int'(e[64]);
            if (obs !== e) begin n_fail++; $display("FAIL fullpop_head got=%h exp=%h", obs, e); end
        end
        n_tests++; if (bus.ob_depth !== 4'd8) begin n_fail++; $display("FAIL fullpop_depth got=%0d exp=8", bus.ob_depth); end
        n_tests++; if (bus.ob_ovfl !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovfl got=%0b exp=0", bus.ob_ovfl); end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, vld, popped, obs);
            n_tests++;
            if (!popped || exp_q.size() == 0) begin
                n_fail++; $display("FAIL fullpop_drain_valid idx=%0d got=%0b exp=1", i, popped);
            end else begin
                e = exp_q.pop_front(); exp_eof += int'(e[64]);
                if (obs !== e) begin n_fail++; $display("FAIL fullpop_drain_data idx=%0d got=%h exp=%h", i, obs, e); end
            end
        end
        n_tests++; if (obs !== {1'b1, 64'h1FF}) begin n_fail++; $display("FAIL fullpop_last_beat got=%h exp=%h", obs, {1'b1, 64'h1FF}); end
    endtask

    task automatic test_backpressure();
        logic vld, popped, wr, rdy, prev_stall;
        logic [64:0] obs, e, prev_obs;
        int sent, rcvd, bad_data, bad_hold;
        apply_reset(1);
        @(negedge clk); rst_n = 1'b1;
        sent = 0; rcvd = 0; bad_data = 0; bad_hold = 0;
        prev_stall = 1'b0; prev_obs = '0;
        for (int cyc = 0; cyc < 4000 && rcvd < 200; cyc++) begin
            wr  = (sent < 200) && !bus.ob_afull;
            rdy = ($urandom_range(0, 9) < 3);
            drive_cycle(wr, {32'(sent), $urandom}, ((sent + 1) % 7) == 0, rdy, 1'b0, vld, popped, obs);
            if (wr) sent++;
            if (prev_stall) begin
                n_tests++;
                if (vld !== 1'b1 || obs !== prev_obs) begin
                    n_fail++; bad_hold++;
                    if (bad_hold < 4) $display("FAIL bp_hold cyc=%0d got=%h exp=%h", cyc, obs, prev_obs);
                end
            end
            if (popped) begin
                rcvd++;
                if (exp_q.size() == 0) bad_data++;
                else begin
                    e = exp_q.pop_front(); exp_eof += int'(e[64]);
                    if (obs !== e) bad_data++;
                end
            end
            prev_stall = vld && !rdy;
            prev_obs   = obs;
        end
        n_tests++; if (rcvd != 200) begin n_fail++; $display("FAIL bp_timeout got=%0d beats exp=200", rcvd); end
        n_tests++; if (bad_data != 0) begin n_fail++; $display("FAIL bp_order got=%0d bad beats exp=0", bad_data); end
        n_tests++; if (bus.ob_eof_cnt !== 16'd28) begin n_fail++; $display("FAIL bp_eof got=%0d exp=28", bus.ob_eof_cnt); end
    endtask

    task automatic test_ovfl_clr();
        logic vld, popped;
        logic [64:0] obs;
        for (int i = 1; i <= 8; i++) drive_cycle(1'b1, 64'h300 + 64'(i), 1'b0, 1'b0, 1'b0, vld, popped, obs);
        drive_cycle(1'b1, 64'h3F0, 1'b0, 1'b0, 1'b0, vld, popped, obs);
        n_tests++; if (bus.ob_ovfl !== 1'b1) begin n_fail++; $display("FAIL ovfl_set got=%0b exp=1", bus.ob_ovfl); end
        drive_cycle(1'b1, 64'h3FF, 1'b0, 1'b0, 1'b1, vld, popped, obs);
        n_tests++; if (bus.ob_ovfl !== 1'b1) begin n_fail++; $display("FAIL ovfl_set_wins got=%0b exp=1", bus.ob_ovfl); end
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, vld, popped, obs);
        n_tests++; if (bus.ob_ovfl !== 1'b0) begin n_fail++; $display("FAIL ovfl_clear got=%0b exp=0", bus.ob_ovfl); end
        n_tests++; if (bus.ob_depth !== 4'd8) begin n_fail++; $display("FAIL ovfl_depth got=%0d exp=8", bus.ob_depth); end
    endtask

    task automatic test_reset_mid();
        logic vld, popped;
        logic [64:0] obs, e;
        int bad;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, vld, popped, obs);
            n_tests++;
            if (!popped || exp_q.size() == 0) begin
                n_fail++; $display("FAIL mid_drain_valid idx=%0d got=%0b exp=1", i, popped);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin n_fail++; $display("FAIL mid_drain_data idx=%0d got=%h exp=%h", i, obs, e); end
            end
        end
        n_tests++; if (bus.ob_depth !== 4'd4) begin n_fail++; $display("FAIL mid_depth_before got=%0d exp=4", bus.ob_depth); end
        apply_reset(1);
        n_tests++; if (bus.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid got=%0b exp=0", bus.m_tvalid); end
        n_tests++; if (bus.ob_depth !== 4'd0) begin n_fail++; $display("FAIL mid_depth got=%0d exp=0", bus.ob_depth); end
        n_tests++; if (bus.ob_eof_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_eof got=%0d exp=0", bus.ob_eof_cnt); end
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            drive_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, vld, popped, obs);
            if (vld !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mid_no_stale got=%0d valid cycles exp=0", bad); end
    endtask

    task automatic test_eof_wrap();
        logic vld, popped;
        logic [64:0] obs, e;
        int pops, bad;
        pops = 0; bad = 0;
        for (int i = 0; i < 65600 && pops < 65536; i++) begin
            drive_cycle(i < 65536, 64'(i), 1'b1, 1'b1, 1'b0, vld, popped, obs);
            if (popped) begin
                pops++;
                if (exp_q.size() == 0) bad++;
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) bad++;
                end
                if (pops == 65535) begin
                    n_tests++; if (bus.ob_eof_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got=%h exp=ffff", bus.ob_eof_cnt); end
                end
            end
        end
        n_tests++; if (pops != 65536) begin n_fail++; $display("FAIL wrap_timeout got=%0d pops exp=65536", pops); end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL wrap_data got=%0d bad beats exp=0", bad); end
        n_tests++; if (bus.ob_eof_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got=%h exp=0000", bus.ob_eof_cnt); end
    endtask

    initial begin
        bus.ob_wr       = 1'b0;
        bus.ob_wdata    = '0;
        bus.ob_wlast    = 1'b0;
        bus.m_tready    = 1'b0;
        bus.ob_ovfl_clr = 1'b0;
        test_reset();
        test_latency();
        test_fill_afull();
        test_full_pop();
        test_backpressure();
        test_ovfl_clr();
        test_reset_mid();
        test_eof_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cr_osf_ob_egress_fifo.md
Name: cr_osf_ob_egress_fifo

Overview:
- Output-buffer FIFO directly downstream of the OSF debug-FIFO control stage.
- Accepts the registered write strobe and beat produced by that stage (ob_wr, ob_wdata, ob_wlast) and back-pressures it with ob_afull.
- Drains stored beats onto an AXI4-stream master towards the OSF egress port.
- Keeps frame and overflow status for CSR readback.
- One instance is used for the data path and one for the PDT path.

Parameters:
- DATA_W, 64: width of ob_wdata / m_tdata (tlast carried separately).
- DEPTH, 8: storage entries; must be ≥4.
- AFULL_MARGIN, 3: headroom entries. Covers the 2-cycle decision-to-write latency upstream plus 1 spare.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- ob_wr  in  1  write strobe; a beat is present when high.
- ob_wdata  in  DATA_W  write beat data.
- ob_wlast  in  1  end-of-frame marker for the beat.
- ob_afull  out  1  almost-full to upstream.
- m_tvalid  out  1  AXI4-stream valid.
- m_tready  in  1  AXI4-stream ready.
- m_tdata  out  DATA_W  AXI4-stream data.
- m_tlast  out  1  AXI4-stream last.
- ob_depth  out  $clog2(DEPTH+1)  current occupancy.
- ob_eof_cnt  out  16  count of frames delivered.
- ob_ovfl  out  1  sticky overflow flag.
- ob_ovfl_clr  in  1  clears ob_ovfl.

Behaviour:
- Clock and reset:
  - Single clock domain, clk. Reset is synchronous and active-low on rst_n.
  - All state updates on posedge clk, and only when rst_n is sampled high.
- Reset values:
  - wptr=0, rptr=0, count=0.
  - m_tvalid=0, ob_afull=0, ob_depth=0, ob_eof_cnt=0, ob_ovfl=0.
  - m_tdata and m_tlast are don't-care while m_tvalid=0; storage is not reset.
- Reset mid-operation: all stored beats are discarded. No partial frame is emitted after reset deasserts.
- Storage: flop array of DEPTH entries, each {wlast, wdata}. wptr and rptr wrap from DEPTH-1 to 0.
- Write rules:
  - Define pop = m_tvalid && m_tready.
  - A write is accepted when ob_wr && (count<DEPTH || pop). It writes mem[wptr] and advances wptr.
  - Write while count==DEPTH and no pop: the beat is dropped, wptr is unchanged, and ob_ovfl is set the next cycle.
- Read rules:
  - m_tvalid = (count!=0).
  - m_tdata and m_tlast are taken from mem[rptr], with no combinational path from the ob_w* inputs.
  - pop advances rptr.
  - m_tdata and m_tlast hold stable while m_tvalid && !m_tready (AXI rule).
- Latency: a beat written at cycle t is visible on m_tvalid at t+1 when the FIFO was empty.
- count update (registered):
  - count += accepted_write − pop.
  - Simultaneous accept and pop leaves count unchanged, including at count==DEPTH.
- Outputs derived from count:
  - ob_depth = count.
  - ob_afull = (count ≥ DEPTH−AFULL_MARGIN), combinational from registered count only.
- Frame counter: ob_eof_cnt increments by 1 on each pop with m_tlast=1 and wraps 0xFFFF→0x0000.
- Overflow flag: ob_ovfl is set by a dropped write. ob_ovfl_clr clears it; if set and clear occur in the same cycle, set wins.
- No internal FSM beyond the pointer/count machine. Frame boundaries are passed through, not enforced.

Test Plan:
- Basic latency and frame count (DEPTH=8, AFULL_MARGIN=3):
  - Stimulus: m_tready=1; single ob_wr at cycle 10 with data 0xA5, wlast=1.
  - Response: m_tvalid=1 only at cycle 11 with m_tdata=0xA5 and m_tlast=1; ob_eof_cnt becomes 1; ob_depth returns to 0.
- Fill and almost-full:
  - Stimulus: m_tready=0; write 8 beats back-to-back.
  - Response: ob_afull rises the cycle ob_depth reaches 5; ob_depth=8; a 9th write sets ob_ovfl and is absent from the output.
  - Drain: draining yields beats 1–8 in order.
- Full with simultaneous pop:
  - Stimulus: count=8; ob_wr and m_tready both high for 1 cycle.
  - Response: write accepted, ob_depth stays 8, ob_ovfl stays 0, and the new beat emerges last.
- Backpressure stability:
  - Stimulus: random m_tready at 30% duty, 200 beats with wlast every 7th beat.
  - Response: m_tdata stable while stalled; output sequence equals input sequence; ob_eof_cnt=28.
- Overflow clear priority:
  - Stimulus: ob_ovfl=1; ob_ovfl_clr=1 in the same cycle as a dropped write.
  - Response: ob_ovfl remains 1.
  - Follow-up: a later clear alone gives ob_ovfl=0.
- Reset mid-frame and counter wrap:
  - Stimulus: rst_n low for 1 cycle with 4 beats queued.
  - Response: next cycle m_tvalid=0, ob_depth=0, ob_eof_cnt=0.
  - Wrap: after 65536 tlast pops, ob_eof_cnt returns to 0x0000.
